// File: rtl/common_defs.sv
// Shared bus widths and mem_ctrl_signal field encodings for the core's data port.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package common_defs;
    localparam int MEM_CTRL_LOAD_BIT  = 4;
    localparam int MEM_CTRL_STORE_BIT = 3;
    localparam int MEM_CTRL_SIGN_BIT  = 2;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
    localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;
endpackage

// File: rtl/mem_pkg.sv
// State encoding for the SRAM access sequencer.
package mem_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ACCESS,
        S_RD_LATCH,
        S_WR_SETUP,
        S_WR_PULSE,
        S_DONE
    } mem_sram_state_t;
endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and lane extraction/extension for loads on a 32-bit bus.
module mem_lane_align
    import common_defs::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr,
    input  logic        sign,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be_n,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        misalign
);
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        be_n       = 4'hF;
        wdata_lane = wdata;
        rdata_ext  = 32'h0;
        misalign   = 1'b0;
        rd_byte    = rdata[{addr, 3'b000} +: 8];
        rd_half    = addr[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            MEM_SIZE_BYTE: begin
                be_n       = ~(4'b0001 << addr);
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = {{24{sign & rd_byte[7]}}, rd_byte};
            end
            MEM_SIZE_HALF: begin
                // addr[0] is ignored so a misaligned half falls onto its natural lane pair
                be_n       = addr[1] ? 4'b0011 : 4'b1100;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = {{16{sign & rd_half[15]}}, rd_half};
                misalign   = addr[0];
            end
            default: begin
                be_n       = 4'b0000;
                wdata_lane = wdata;
                rdata_ext  = rdata;
                misalign   = |addr;
            end
        endcase
    end
endmodule

// File: rtl/mem_sram_ctrl.sv
// Data-port controller for an asynchronous 32-bit SRAM; sequences strobes and stalls the core.
module mem_sram_ctrl
    import common_defs::*;
    import mem_pkg::*;
#(
    parameter int SRAM_AW     = 20,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                   clk_50M,
    input  logic                   reset_btn,
    input  logic [`ADDR_WIDTH-1:0] mem_addr,
    input  logic [`DATA_WIDTH-1:0] mem_wdata,
    input  logic [4:0]             mem_ctrl_signal,
    output logic [`DATA_WIDTH-1:0] mem_rdata,
    output logic                   mem_stall,
    output logic                   mem_misalign,
    output logic [SRAM_AW-1:0]     sram_addr,
    output logic [31:0]            sram_wdata,
    input  logic [31:0]            sram_rdata,
    output logic                   sram_data_oe,
    output logic                   sram_ce_n,
    output logic                   sram_oe_n,
    output logic                   sram_we_n,
    output logic [3:0]             sram_be_n
);
    localparam logic [2:0] WAIT_LAST = 3'(WAIT_CYCLES);

    mem_sram_state_t state;
    logic [2:0] cnt;
    logic [1:0] r_size, r_off;
    logic       r_sign, r_misalign;

    logic req, is_store;
    assign req       = mem_ctrl_signal[MEM_CTRL_LOAD_BIT] | mem_ctrl_signal[MEM_CTRL_STORE_BIT];
    assign is_store  = mem_ctrl_signal[MEM_CTRL_STORE_BIT];
    assign mem_stall = req & (state != S_DONE);

    logic unused_addr_hi;
    assign unused_addr_hi = ^mem_addr[`ADDR_WIDTH-1:SRAM_AW+2];

    // Live request fields steer the store in IDLE; latched fields drive load extraction later.
    logic        idle;
    logic [3:0]  al_be_n;
    logic [31:0] al_wdata, al_rdata;
    logic        al_misalign;
    assign idle = (state == S_IDLE);

    mem_lane_align u_align (
        .size       (idle ? mem_ctrl_signal[1:0] : r_size),
        .addr       (idle ? mem_addr[1:0] : r_off),
        .sign       (idle ? mem_ctrl_signal[MEM_CTRL_SIGN_BIT] : r_sign),
        .wdata      (mem_wdata[31:0]),
        .rdata      (sram_rdata),
        .be_n       (al_be_n),
        .wdata_lane (al_wdata),
        .rdata_ext  (al_rdata),
        .misalign   (al_misalign)
    );

    always_ff @(posedge clk_50M) begin
        if (reset_btn) begin
            state        <= S_IDLE;
            cnt          <= 3'd0;
            r_size       <= 2'b00;
            r_off        <= 2'b00;
            r_sign       <= 1'b0;
            r_misalign   <= 1'b0;
            sram_ce_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
            sram_we_n    <= 1'b1;
            sram_be_n    <= 4'hF;
            sram_data_oe <= 1'b0;
            sram_addr    <= '0;
            sram_wdata   <= 32'h0;
            mem_rdata    <= '0;
            mem_misalign <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (req) begin
                    r_size     <= mem_ctrl_signal[1:0];
                    r_off      <= mem_addr[1:0];
                    r_sign     <= mem_ctrl_signal[MEM_CTRL_SIGN_BIT];
                    r_misalign <= al_misalign;
                    sram_addr  <= mem_addr[SRAM_AW+1:2];
                    sram_ce_n  <= 1'b0;
                    cnt        <= 3'd0;
                    if (is_store) begin
                        sram_be_n    <= al_be_n;
                        sram_wdata   <= al_wdata;
                        sram_data_oe <= 1'b1;
                        state        <= S_WR_SETUP;
                    end else begin
                        sram_oe_n <= 1'b0;
                        sram_be_n <= 4'b0000;
                        state     <= S_RD_ACCESS;
                    end
                end
                S_RD_ACCESS: begin
                    if (cnt == WAIT_LAST) state <= S_RD_LATCH;
                    else                  cnt   <= cnt + 3'd1;
                end
                S_RD_LATCH: begin
                    mem_rdata    <= al_rdata;
                    mem_misalign <= r_misalign;
                    sram_ce_n    <= 1'b1;
                    sram_oe_n    <= 1'b1;
                    sram_be_n    <= 4'hF;
                    state        <= S_DONE;
                end
                S_WR_SETUP: begin
                    sram_we_n <= 1'b0;
                    cnt       <= 3'd0;
                    state     <= S_WR_PULSE;
                end
                S_WR_PULSE: begin
                    if (cnt == WAIT_LAST) begin
                        // data_oe stays up through DONE for data hold after we_n rises
                        sram_we_n    <= 1'b1;
                        sram_ce_n    <= 1'b1;
                        sram_be_n    <= 4'hF;
                        mem_misalign <= r_misalign;
                        state        <= S_DONE;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                S_DONE: begin
                    mem_misalign <= 1'b0;
                    sram_data_oe <= 1'b0;
                    state        <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Directed scoreboard bench for mem_sram_ctrl with behavioural SRAM models (WAIT_CYCLES 1 and 0).
module tb_mem_sram_ctrl;
    logic        clk = 1'b0;
    logic        reset_btn;
    logic [31:0] addr0, wdata0, addr1, wdata1;
    logic [4:0]  ctrl0, ctrl1;
    logic [31:0] rdata0, rdata1, swd0, swd1, srd0, srd1;
    logic        stall0, stall1, mis0, mis1;
    logic [19:0] sa0, sa1;
    logic        oe0, oe1, ce0, ce1, roe0, roe1, we0, we1;
    logic [3:0]  be0, be1;

    always #10 clk = ~clk;

    mem_sram_ctrl #(.SRAM_AW(20), .WAIT_CYCLES(1)) dut (
        .clk_50M(clk), .reset_btn(reset_btn), .mem_addr(addr0), .mem_wdata(wdata0),
        .mem_ctrl_signal(ctrl0), .mem_rdata(rdata0), .mem_stall(stall0), .mem_misalign(mis0),
        .sram_addr(sa0), .sram_wdata(swd0), .sram_rdata(srd0), .sram_data_oe(oe0),
        .sram_ce_n(ce0), .sram_oe_n(roe0), .sram_we_n(we0), .sram_be_n(be0));

    mem_sram_ctrl #(.SRAM_AW(20), .WAIT_CYCLES(0)) dut_w0 (
        .clk_50M(clk), .reset_btn(reset_btn), .mem_addr(addr1), .mem_wdata(wdata1),
        .mem_ctrl_signal(ctrl1), .mem_rdata(rdata1), .mem_stall(stall1), .mem_misalign(mis1),
        .sram_addr(sa1), .sram_wdata(swd1), .sram_rdata(srd1), .sram_data_oe(oe1),
        .sram_ce_n(ce1), .sram_oe_n(roe1), .sram_we_n(we1), .sram_be_n(be1));

    // Small SRAM models: 16 words, write committed on any edge that sees ce_n and we_n low.
    logic [31:0] mem0 [0:15];
    logic [31:0] mem1 [0:15];
    assign srd0 = !roe0 ? mem0[sa0[3:0]] : 32'h0;
    assign srd1 = !roe1 ? mem1[sa1[3:0]] : 32'h0;
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (!ce0 && !we0 && !be0[b]) mem0[sa0[3:0]][8*b +: 8] <= swd0[8*b +: 8];
            if (!ce1 && !we1 && !be1[b]) mem1[sa1[3:0]][8*b +: 8] <= swd1[8*b +: 8];
        end
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    typedef struct { logic [31:0] rd; logic mis; int stalls; } exp_t;
    exp_t sb [$];

    bit          sel;
    int          we_low;
    logic [3:0]  be_wr;
    logic [19:0] addr_seen;
    logic [31:0] wd_seen;

    task automatic access(input bit s, input logic [4:0] ctrl, input logic [31:0] a,
                          input logic [31:0] wd, input int exp_stalls,
                          input logic [31:0] exp_rd, input logic exp_mis);
        int n;
        bit done;
        exp_t e;
        sb.push_back('{rd: exp_rd, mis: exp_mis, stalls: exp_stalls});
        sel = s;
        @(posedge clk); #1;
        if (s) begin ctrl1 = ctrl; addr1 = a; wdata1 = wd; end
        else   begin ctrl0 = ctrl; addr0 = a; wdata0 = wd; end
        n = 0; done = 0; we_low = 0; be_wr = 4'hF; addr_seen = '1; wd_seen = 32'h0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if ((s ? stall1 : stall0)) n++;
            else done = 1;
            if (!(s ? ce1 : ce0)) addr_seen = s ? sa1 : sa0;
            if (!(s ? we1 : we0)) begin
                we_low++;
                be_wr   = s ? be1 : be0;
                wd_seen = s ? swd1 : swd0;
            end
            if (done) begin
                e = sb.pop_front();
                chk("stall_cycles", n, e.stalls);
                chk("rdata", s ? rdata1 : rdata0, e.rd);
                chk("misalign", {31'h0, s ? mis1 : mis0}, {31'h0, e.mis});
            end
        end
        chk("done_reached", {31'h0, done}, 32'h1);
        if (!done) void'(sb.pop_front());
        @(posedge clk); #1;
        ctrl0 = 5'b0; ctrl1 = 5'b0;
        @(negedge clk);
        chk("mis_one_cycle", {31'h0, s ? mis1 : mis0}, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 16; i++) begin mem0[i] = 32'h0; mem1[i] = 32'h0; end
        mem0[1] = 32'h12345678;
        mem0[8] = 32'h11111111;
        reset_btn = 1'b1;
        ctrl0 = 5'b0; addr0 = 32'h0; wdata0 = 32'h0;
        ctrl1 = 5'b0; addr1 = 32'h0; wdata1 = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ce_n", {31'h0, ce0}, 32'h1);
        chk("rst_oe_n", {31'h0, roe0}, 32'h1);
        chk("rst_we_n", {31'h0, we0}, 32'h1);
        chk("rst_be_n", {28'h0, be0}, 32'hF);
        chk("rst_data_oe", {31'h0, oe0}, 32'h0);
        chk("rst_rdata", rdata0, 32'h0);
        chk("rst_misalign", {31'h0, mis0}, 32'h0);
        chk("rst_sram_addr", {12'h0, sa0}, 32'h0);
        chk("rst_sram_wdata", swd0, 32'h0);
        chk("rst_stall", {31'h0, stall0}, 32'h0);
        reset_btn = 1'b0;

        // 1: word store
        access(0, 5'b01010, 32'h80000010, 32'hDEADBEEF, 4, 32'h0, 1'b0);
        chk("t1_addr", {12'h0, addr_seen}, 32'h00004);
        chk("t1_be", {28'h0, be_wr}, 32'h0);
        chk("t1_we_low", we_low, 2);
        chk("t1_wdata", wd_seen, 32'hDEADBEEF);
        chk("t1_mem", mem0[4], 32'hDEADBEEF);

        // 2: byte store then signed / unsigned byte loads
        access(0, 5'b01000, 32'h80000013, 32'h000000A5, 4, 32'h0, 1'b0);
        chk("t2_be", {28'h0, be_wr}, 32'h7);
        chk("t2_wdata", wd_seen, 32'hA5A5A5A5);
        chk("t2_mem", mem0[4], 32'hA5ADBEEF);
        access(0, 5'b10100, 32'h80000013, 32'h0, 4, 32'hFFFFFFA5, 1'b0);
        access(0, 5'b10000, 32'h80000013, 32'h0, 4, 32'h000000A5, 1'b0);

        // 3: halfword store at offset 2, signed and unsigned loads
        access(0, 5'b01001, 32'h80000012, 32'h00008001, 4, 32'h000000A5, 1'b0);
        chk("t3_be", {28'h0, be_wr}, 32'h3);
        chk("t3_mem", mem0[4], 32'h8001BEEF);
        access(0, 5'b10101, 32'h80000012, 32'h0, 4, 32'hFFFF8001, 1'b0);
        access(0, 5'b10001, 32'h80000012, 32'h0, 4, 32'h00008001, 1'b0);
        access(0, 5'b10100, 32'h80000010, 32'h0, 4, 32'hFFFFFFEF, 1'b0);

        // 4: misaligned word load
        access(0, 5'b10010, 32'h80000006, 32'h0, 4, 32'h12345678, 1'b1);
        chk("t4_addr", {12'h0, addr_seen}, 32'h00001);

        // 5: reset during the write pulse
        sel = 0;
        @(posedge clk); #1;
        ctrl0 = 5'b01010; addr0 = 32'h80000020; wdata0 = 32'h0BADF00D;
        repeat (3) @(negedge clk);
        chk("t5_in_pulse", {31'h0, we0}, 32'h0);
        reset_btn = 1'b1; ctrl0 = 5'b0;
        @(negedge clk);
        chk("t5_we_n", {31'h0, we0}, 32'h1);
        chk("t5_ce_n", {31'h0, ce0}, 32'h1);
        chk("t5_data_oe", {31'h0, oe0}, 32'h0);
        chk("t5_stall", {31'h0, stall0}, 32'h0);
        reset_btn = 1'b0;
        access(0, 5'b10010, 32'h80000020, 32'h0, 4, 32'h0BADF00D, 1'b0);

        // 6: load+store together on the zero-wait instance is a store
        access(1, 5'b11010, 32'h80000020, 32'hCAFEF00D, 3, 32'h0, 1'b0);
        chk("t6_we_low", we_low, 1);
        chk("t6_mem", mem1[8], 32'hCAFEF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
